imm_encode: RTL
===============

Name: imm_encode

Overview:
- Inverse of the decode-stage immediate sign extender.
- Takes a 32-bit signed value and packs it into the 23-bit instruction immediate field, choosing the format code (`EXT16/`EXT17/`EXT22/`EXT23 from defines.v) that the decoder will sign-extend back to the same value.
- Two-stage valid/ready pipeline. Used by the instruction-memory loader / test-program generator to build instruction words.
- Flags values that cannot be represented, and keeps a saturating count of them.

Parameters:
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  an input beat is presented.
- in_ready  output  1  block can accept a beat this cycle.
- in_value  input  32  signed value to encode.
- in_auto  input  1  1 = pick the smallest fitting format; 0 = use in_fmt.
- in_fmt  input  2  requested format code when in_auto = 0.
- out_valid  output  1  encoded beat available.
- out_ready  input  1  consumer accepts the beat.
- out_imm  output  23  packed immediate field.
- out_fmt  output  2  format code for the decoder's msb input.
- out_err  output  1  value not representable in out_fmt.
- err_cnt  output  CNT_W  number of out_err beats accepted, saturating.
- err_clr  input  1  synchronous clear of err_cnt.

Behaviour:
- Reset (async assert, sync release): both stage valids are 0, out_valid is 0, out_imm, out_fmt and out_err are 0, err_cnt is 0. A reset mid-operation drops all in-flight beats.
- Fit rule for width N (16, 17, 22, 23): the value fits iff in_value[31:N-1] are all equal.
- Packing:
  - out_imm[N-1:0] = in_value[N-1:0].
  - out_imm[22:N] = 0. The decoder ignores these bits.
- Explicit mode (in_auto = 0):
  - out_fmt = in_fmt.
  - out_err = !fit(N).
  - The truncated field is still emitted.
  - A code outside the four defined codes gives out_err = 1, out_imm = 0, out_fmt = in_fmt.
- Auto mode (in_auto = 1):
  - out_fmt is the first fitting format in the order EXT16, EXT17, EXT22, EXT23.
  - If none fits: out_fmt = EXT23, out_err = 1, out_imm = in_value[22:0].
- Round-trip invariant: when out_err = 0, sign-extending out_imm by out_fmt per the decoder rule reproduces in_value exactly.
- Stage 1:
  - Registers the value and the fit vector (4 bits, computed combinationally from in_value) on an input handshake.
  - Holds its contents while stalled.
- Stage 2:
  - Registers format selection and packing.
  - Drives the out_* ports directly from flops (no combinational path from in_* to out_*).
- Handshake:
  - A transfer occurs when valid && ready on the same edge.
  - Stage 2 advances when !s2_valid || out_ready.
  - Stage 1 advances when !s1_valid || s2 advances.
  - in_ready = stage-1 advance condition. This is the only combinational path, out_ready -> in_ready.
  - out_* are stable while out_valid && !out_ready.
- Latency and throughput: 2 cycles from input handshake to out_valid, with out_ready held high; one beat per cycle sustained.
- Back-pressure: with out_ready = 0, at most 2 beats are buffered, then in_ready = 0. No beat is dropped or duplicated.
- err_cnt:
  - Increments on each output handshake with out_err = 1.
  - Saturates at all-ones.
  - err_clr has priority: if clear and increment happen in the same cycle, the result is 0.

Test Plan:
- Auto mode, out_ready = 1, values 0x00007FFF, 0x00008000, 0xFFFF8000, 0x00200000 back to back -> outputs two cycles later:
  - EXT16 / 0x007FFF
  - EXT17 / 0x008000
  - EXT16 / 0x008000
  - EXT23 / 0x200000
  - All with err = 0, one beat per cycle.
- Auto mode, 0x00400000 and 0x80000000 -> EXT23, out_imm = 0x400000 and 0x000000, err = 1 on both; err_cnt = 2.
- Explicit EXT16 with 0x00010000 -> out_imm = 0x000000, err = 1. Explicit EXT22 with 0xFFE00000 -> out_imm = 0x200000, err = 0.
- Hold out_ready = 0 while streaming 5 beats:
  - in_ready drops after 2 accepted beats.
  - out_* stay stable.
  - Releasing out_ready delivers all beats in order with no loss.
- Force err_cnt to all-ones with CNT_W = 4 (16 error beats) -> stays 0xF. An err_clr coincident with an error handshake -> 0.
- Assert rst_n low mid-stream with both stages full -> out_valid = 0 immediately (async); after release, the first new beat emerges with 2-cycle latency.
- Random regression: for every out_err = 0 beat, a reference sign-extension of out_imm by out_fmt equals in_value.

Source files
------------

// File: rtl/imm_encode.sv
// Immediate encoder: packs a 32-bit signed value into the 23-bit instruction
// immediate field and selects the sign-extension format the decoder will apply.
module imm_encode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_value,
  input  logic             in_auto,
  input  logic [1:0]       in_fmt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [22:0]      out_imm,
  output logic [1:0]       out_fmt,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    EXT16 = 2'b00,
    EXT17 = 2'b01,
    EXT22 = 2'b10,
    EXT23 = 2'b11
  } fmt_e;

  logic        s1_valid;
  logic [22:0] s1_value;
  logic [3:0]  s1_fit;
  logic        s1_auto;
  logic [1:0]  s1_fmt;

  logic        s1_adv;
  logic        s2_adv;
  logic [3:0]  fit;

  fmt_e        sel_fmt;
  logic [22:0] sel_mask;
  logic        sel_fit;
  logic [22:0] sel_imm;

  // Value fits width N when bits [31:N-1] are all copies of the sign bit.
  always_comb begin
    fit[0] = (&in_value[31:15]) | ~(|in_value[31:15]);
    fit[1] = (&in_value[31:16]) | ~(|in_value[31:16]);
    fit[2] = (&in_value[31:21]) | ~(|in_value[31:21]);
    fit[3] = (&in_value[31:22]) | ~(|in_value[31:22]);
  end

  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_fit   <= '0;
      s1_auto  <= 1'b0;
      s1_fmt   <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_value <= in_value[22:0];
        s1_fit   <= fit;
        s1_auto  <= in_auto;
        s1_fmt   <= in_fmt;
      end
    end
  end

  // In auto mode with no fitting format, EXT23 is chosen and its fit bit is
  // 0, so the error falls out of the same !fit test used in explicit mode.
  always_comb begin
    sel_fmt  = fmt_e'(s1_fmt);
    sel_mask = '0;
    sel_fit  = 1'b0;
    if (s1_auto) begin
      if (s1_fit[0])      sel_fmt = EXT16;
      else if (s1_fit[1]) sel_fmt = EXT17;
      else if (s1_fit[2]) sel_fmt = EXT22;
      else                sel_fmt = EXT23;
    end
    case (sel_fmt)
      EXT16: begin sel_mask = 23'h00FFFF; sel_fit = s1_fit[0]; end
      EXT17: begin sel_mask = 23'h01FFFF; sel_fit = s1_fit[1]; end
      EXT22: begin sel_mask = 23'h3FFFFF; sel_fit = s1_fit[2]; end
      EXT23: begin sel_mask = 23'h7FFFFF; sel_fit = s1_fit[3]; end
      default: begin sel_mask = '0; sel_fit = 1'b0; end
    endcase
    sel_imm = s1_value & sel_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_imm <= sel_imm;
        out_fmt <= sel_fmt;
        out_err <= !sel_fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
